hazard_ctrl: RTL

- Consumer end of the E-stage register interface. Takes E's destination/Tnew report (regWA_E, regWE_E, Tnew_E) plus D-stage source/Tuse info.
- Drives the stall to F/D and the flush into the E register; selects operand forwarding for D and E.
- Keeps its own shadow copies of the M and W destination slots, with Tnew decremented per stage.
- Tracks the multiply/divide busy window.

---
 rtl/hazard_ctrl_pkg.sv | 46 ++++
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/md_busy_counter.sv | 38 +++
 rtl/hazard_ctrl.sv | 73 +++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the hazard controller: shadow-slot layout, forwarding
// encodings and the slot match / stall / forward-select rules.
package hazard_ctrl_pkg;

  localparam int unsigned TW = 3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [TW-1:0] TUSE_NONE = TW'(7);

  typedef struct packed {
    logic [4:0]    wa;
    logic          we;
    logic [TW-1:0] tnew;
  } slot_t;

  function automatic logic [TW-1:0] sat_dec(logic [TW-1:0] x);
    return (x == '0) ? '0 : x - TW'(1);
  endfunction

  // Register 0 is hardwired, so it never matches a producer.
  function automatic logic slot_match(slot_t s, logic [4:0] src);
    return s.we && (s.wa == src) && (src != 5'd0);
  endfunction

  function automatic logic data_stall(slot_t e, slot_t m, logic [4:0] src, logic [TW-1:0] tuse);
    return (slot_match(e, src) && (e.tnew > tuse)) || (slot_match(m, src) && (m.tnew > tuse));
  endfunction

  function automatic logic [1:0] fwd_d_sel(slot_t e, slot_t m, slot_t w, logic [4:0] src);
    if (slot_match(e, src) && (e.tnew == '0)) return FWD_E;
    else if (slot_match(m, src))              return FWD_M;
    else if (slot_match(w, src))              return FWD_W;
    else                                      return FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(slot_t m, slot_t w, logic [4:0] src);
    if (slot_match(m, src))      return FWD_M;
    else if (slot_match(w, src)) return FWD_W;
    else                         return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: D/E register reports in, stall and
// forwarding selects out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0]    regRA1_D;
  logic [4:0]    regRA2_D;
  logic [TW-1:0] Tuse1_D;
  logic [TW-1:0] Tuse2_D;
  logic          mdUse_D;
  logic [4:0]    regRA1_E;
  logic [4:0]    regRA2_E;
  logic [4:0]    regWA_E;
  logic          regWE_E;
  logic [TW-1:0] Tnew_E;
  logic          mdStart_E;
  logic          mdDiv_E;
  logic          stall;
  logic          flush_E;
  logic [1:0]    fwdD1;
  logic [1:0]    fwdD2;
  logic [1:0]    fwdE1;
  logic [1:0]    fwdE2;
  logic          mdBusy;

  modport master (
    output regRA1_D, regRA2_D, Tuse1_D, Tuse2_D, mdUse_D,
    output regRA1_E, regRA2_E, regWA_E, regWE_E, Tnew_E, mdStart_E, mdDiv_E,
    input  stall, flush_E, fwdD1, fwdD2, fwdE1, fwdE2, mdBusy
  );

  modport slave (
    input  regRA1_D, regRA2_D, Tuse1_D, Tuse2_D, mdUse_D,
    input  regRA1_E, regRA2_E, regWA_E, regWE_E, Tnew_E, mdStart_E, mdDiv_E,
    output stall, flush_E, fwdD1, fwdD2, fwdE1, fwdE2, mdBusy
  );

endinterface

// File: rtl/md_busy_counter.sv
// HI/LO busy window: loads a mult/div latency on start and counts down to idle.
module md_busy_counter #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic isDiv,
  output logic busy
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A start while still counting reloads rather than extends.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = isDiv ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = start || (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, flush and forwarding control for the D/E stages, using shadow copies of the
// M and W destination slots derived from E's report.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  slot_t e_slot, m_q, w_q;
  logic  md_busy;
  logic  stall_d1, stall_d2, stall_md, stall_any;

  assign e_slot = '{wa: hz.regWA_E, we: hz.regWE_E, tnew: hz.Tnew_E};

  // E/M/W always advance; a bubble in E simply arrives here with we=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= '{wa: e_slot.wa, we: e_slot.we, tnew: sat_dec(e_slot.tnew)};
      w_q <= '{wa: m_q.wa, we: m_q.we, tnew: sat_dec(m_q.tnew)};
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk   (clk),
    .reset (reset),
    .start (hz.mdStart_E),
    .isDiv (hz.mdDiv_E),
    .busy  (md_busy)
  );

  assign stall_d1  = data_stall(e_slot, m_q, hz.regRA1_D, hz.Tuse1_D);
  assign stall_d2  = data_stall(e_slot, m_q, hz.regRA2_D, hz.Tuse2_D);
  assign stall_md  = hz.mdUse_D && md_busy;
  assign stall_any = stall_d1 || stall_d2 || stall_md;

  assign hz.stall   = stall_any;
  assign hz.flush_E = stall_any;
  assign hz.mdBusy  = md_busy;
  assign hz.fwdD1   = fwd_d_sel(e_slot, m_q, w_q, hz.regRA1_D);
  assign hz.fwdD2   = fwd_d_sel(e_slot, m_q, w_q, hz.regRA2_D);
  assign hz.fwdE1   = fwd_e_sel(m_q, w_q, hz.regRA1_E);
  assign hz.fwdE2   = fwd_e_sel(m_q, w_q, hz.regRA2_E);

  // E must never be handed a value its producer has not computed yet.
  logic e_reads_unready;
  always_comb begin
    e_reads_unready = 1'b0;
    if ((slot_match(m_q, hz.regRA1_E) && (m_q.tnew != '0)) ||
        (slot_match(m_q, hz.regRA2_E) && (m_q.tnew != '0)) ||
        (slot_match(w_q, hz.regRA1_E) && (w_q.tnew != '0)) ||
        (slot_match(w_q, hz.regRA2_E) && (w_q.tnew != '0))) begin
      e_reads_unready = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!e_reads_unready);
    end
  end

endmodule
